// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared types and constants for the iterative divider
package iterative_divider_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    D_IDLE,
    D_INIT,
    D_CALC,
    D_SIGN
  } div_states_e;

  // Decoded operation, one-hot over the full execute-stage opcode space.
  typedef enum logic [56:0] {
    NOP    = 57'd1 << 0,
    LUI    = 57'd1 << 1,
    ADD    = 57'd1 << 2,
    SUB    = 57'd1 << 3,
    MUL    = 57'd1 << 45,
    MULH   = 57'd1 << 46,
    MULHSU = 57'd1 << 47,
    MULHU  = 57'd1 << 48,
    DIV    = 57'd1 << 49,
    DIVU   = 57'd1 << 50,
    REM    = 57'd1 << 51,
    REMU   = 57'd1 << 52
  } iType_e;

  function automatic logic is_div_op(input logic [56:0] op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  function automatic logic is_signed_op(input logic [56:0] op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input logic [56:0] op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/iterative_divider_div_step.sv
// rtl/iterative_divider_div_step.sv - one combinational restoring division step
module div_step
  import iterative_divider_pkg::*;
(
  input  logic [DIV_XLEN-1:0] rem_i,
  input  logic                dividend_bit_i,
  input  logic [DIV_XLEN-1:0] divisor_i,
  output logic [DIV_XLEN-1:0] rem_o,
  output logic                quotient_bit_o
);

  logic [DIV_XLEN:0] shifted;
  logic [DIV_XLEN:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference if it did not borrow.
  always_comb begin
    shifted        = {rem_i, dividend_bit_i};
    diff           = shifted - {1'b0, divisor_i};
    quotient_bit_o = ~diff[DIV_XLEN];
    rem_o          = quotient_bit_o ? diff[DIV_XLEN-1:0] : shifted[DIV_XLEN-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle RV32M divider (DIV_RESULT_REUSE_EN keeps the last result for reuse)
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [56:0] instruction_operation_i,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  input  logic        flush_i,
  output logic        hold_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int         STEPS    = DIV_XLEN / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(STEPS - 1);

  div_states_e state_q, state_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] div_q, div_d, quo_q, quo_d, rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d, rem_sel_q, rem_sel_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic        special_q, special_d, done_q, done_d;
  logic [31:0] abs_a, abs_b, q_fin, r_fin;
  logic        accept;

`ifdef DIV_RESULT_REUSE_EN
  logic [31:0] last_a_q, last_a_d, last_b_q, last_b_d;
  logic [31:0] last_quo_q, last_quo_d, last_rem_q, last_rem_d;
  logic        last_signed_q, last_signed_d, last_valid_q, last_valid_d;
  logic        reuse_hit;
`endif

  logic [BITS_PER_CYCLE:0][31:0] chain_rem;
  logic [BITS_PER_CYCLE-1:0]     chain_q;

  assign chain_rem[0] = rem_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step u_step (
      .rem_i          (chain_rem[i]),
      .dividend_bit_i (quo_q[DIV_XLEN-1-i]),
      .divisor_i      (div_q),
      .rem_o          (chain_rem[i+1]),
      .quotient_bit_o (chain_q[BITS_PER_CYCLE-1-i])
    );
  end

  assign hold_o   = (state_q != D_IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

  // Next-state and datapath sequencing; flush overrides everything at the end.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    div_d     = div_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    done_d    = 1'b0;
    accept    = (state_q == D_IDLE) && start_i && !flush_i &&
                is_div_op(instruction_operation_i);
    abs_a     = (signed_q && op_a_q[31]) ? -op_a_q : op_a_q;
    abs_b     = (signed_q && op_b_q[31]) ? -op_b_q : op_b_q;
    // Special-case results were loaded already final, so they skip the sign fixup.
    q_fin     = (!special_q && q_neg_q) ? -quo_q : quo_q;
    r_fin     = (!special_q && r_neg_q) ? -rem_q : rem_q;
`ifdef DIV_RESULT_REUSE_EN
    last_a_d      = last_a_q;
    last_b_d      = last_b_q;
    last_quo_d    = last_quo_q;
    last_rem_d    = last_rem_q;
    last_signed_d = last_signed_q;
    last_valid_d  = last_valid_q;
    reuse_hit     = last_valid_q && (first_operand_i == last_a_q) &&
                    (second_operand_i == last_b_q) &&
                    (is_signed_op(instruction_operation_i) == last_signed_q);
`endif

    case (state_q)
      D_IDLE: begin
        if (accept) begin
          op_a_d    = first_operand_i;
          op_b_d    = second_operand_i;
          signed_d  = is_signed_op(instruction_operation_i);
          rem_sel_d = is_rem_op(instruction_operation_i);
          state_d   = D_INIT;
`ifdef DIV_RESULT_REUSE_EN
          if (reuse_hit) begin
            quo_d     = last_quo_q;
            rem_d     = last_rem_q;
            special_d = 1'b1;
            state_d   = D_SIGN;
          end
`endif
        end
      end
      D_INIT: begin
        q_neg_d   = signed_q && (op_a_q[31] ^ op_b_q[31]);
        r_neg_d   = signed_q && op_a_q[31];
        special_d = 1'b0;
        if (op_b_q == 32'd0) begin
          quo_d     = 32'hFFFF_FFFF;
          rem_d     = op_a_q;
          special_d = 1'b1;
          state_d   = D_SIGN;
        end else if (signed_q && op_a_q == 32'h8000_0000 && op_b_q == 32'hFFFF_FFFF) begin
          quo_d     = 32'h8000_0000;
          rem_d     = 32'd0;
          special_d = 1'b1;
          state_d   = D_SIGN;
        end else begin
          rem_d   = 32'd0;
          quo_d   = abs_a;
          div_d   = abs_b;
          cnt_d   = CNT_INIT;
          state_d = D_CALC;
        end
      end
      D_CALC: begin
        // quo_q doubles as the dividend shift register: dividend bits leave at the top,
        // quotient bits enter at the bottom.
        rem_d = chain_rem[BITS_PER_CYCLE];
        quo_d = {quo_q[DIV_XLEN-1-BITS_PER_CYCLE:0], chain_q};
        if (cnt_q == 5'd0) begin
          state_d = D_SIGN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      D_SIGN: begin
        result_d = rem_sel_q ? r_fin : q_fin;
        done_d   = 1'b1;
        state_d  = D_IDLE;
`ifdef DIV_RESULT_REUSE_EN
        last_a_d      = op_a_q;
        last_b_d      = op_b_q;
        last_signed_d = signed_q;
        last_quo_d    = q_fin;
        last_rem_d    = r_fin;
        last_valid_d  = 1'b1;
`endif
      end
      default: state_d = D_IDLE;
    endcase

    if (flush_i) begin
      state_d  = D_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
`ifdef DIV_RESULT_REUSE_EN
      last_valid_d = 1'b0;
`endif
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= D_IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      done_q    <= done_d;
    end
  end

`ifdef DIV_RESULT_REUSE_EN
  // Last-result store used to short-circuit a matching follow-up operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_a_q      <= '0;
      last_b_q      <= '0;
      last_quo_q    <= '0;
      last_rem_q    <= '0;
      last_signed_q <= 1'b0;
      last_valid_q  <= 1'b0;
    end else begin
      last_a_q      <= last_a_d;
      last_b_q      <= last_b_d;
      last_quo_q    <= last_quo_d;
      last_rem_q    <= last_rem_d;
      last_signed_q <= last_signed_d;
      last_valid_q  <= last_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int N = 1;
`ifdef DIV_RESULT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [56:0] instruction_operation_i;
  logic [31:0] first_operand_i;
  logic [31:0] second_operand_i;
  logic        flush_i;
  logic        hold_o;
  logic        done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad = 0;
  int cyc;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];

  logic [31:0] last_res = 32'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_s = 1'b0, m_valid = 1'b0;

  iterative_divider #(.BITS_PER_CYCLE(N)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .start_i                 (start_i),
    .instruction_operation_i (instruction_operation_i),
    .first_operand_i         (first_operand_i),
    .second_operand_i        (second_operand_i),
    .flush_i                 (flush_i),
    .hold_o                  (hold_o),
    .done_o                  (done_o),
    .result_o                (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [56:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic sp);
    logic s, r;
    int   sa, sb;
    logic [31:0] q, rm;
    s  = (op == DIV) || (op == REM);
    r  = (op == REM) || (op == REMU);
    sa = a;
    sb = b;
    sp = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; rm = a; sp = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; rm = 32'd0; sp = 1'b1;
    end else if (s) begin
      q = sa / sb; rm = sa % sb;
    end else begin
      q = a / b; rm = a % b;
    end
    return r ? rm : q;
  endfunction

  task automatic run_op(input string tag, input logic [56:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic sp, s, hit;
    int   lat;
    s   = (op == DIV) || (op == REM);
    hit = m_valid && m_a == a && m_b == b && m_s == s;
    exp_res_q.push_back(model(op, a, b, sp));
    lat = (REUSE && hit) ? 2 : (sp ? 3 : 3 + 32 / N);
    exp_lat_q.push_back(lat);
    instruction_operation_i = op;
    first_operand_i = a;
    second_operand_i = b;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    instruction_operation_i = NOP;
    cyc = 1;
    check({tag, "_hold_t1"}, {31'd0, hold_o}, 32'd1);
    while (!done_o && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_o) begin
      check({tag, "_timeout"}, {31'd0, done_o}, 32'd1);
      void'(exp_res_q.pop_front());
      void'(exp_lat_q.pop_front());
    end else begin
      last_res = exp_res_q.pop_front();
      check({tag, "_latency"}, cyc, exp_lat_q.pop_front());
      check({tag, "_result"}, result_o, last_res);
      check({tag, "_hold_done"}, {31'd0, hold_o}, 32'd0);
      m_a = a; m_b = b; m_s = s; m_valid = 1'b1;
    end
  endtask

  initial begin
    logic [56:0] ops[4];
    int seen;
    ops = '{DIV, DIVU, REM, REMU};
    reset_n = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    instruction_operation_i = NOP;
    first_operand_i = 32'd0;
    second_operand_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {31'd0, hold_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // non-divide op with start must be ignored
    instruction_operation_i = MUL;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignore_mul_hold", {31'd0, hold_o}, 32'd0);

    run_op("divu_100_7", DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", REMU, 32'd100, 32'd7);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5_0", DIV, 32'd5, 32'd0);
    run_op("rem_5_0", REM, 32'd5, 32'd0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_1000_33", DIV, 32'd1000, 32'd33);
    run_op("rem_1000_33", REM, 32'd1000, 32'd33);
    run_op("divu_max", DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("rem_neg_neg", REM, 32'hFFFF_FF00, 32'hFFFF_FFF3);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], $urandom,
             $urandom >> $urandom_range(0, 28));
    end

    // flush in the middle of a calculation
    instruction_operation_i = DIVU;
    first_operand_i = 32'd123456;
    second_operand_i = 32'd789;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_valid = 1'b0;
    check("flush_hold_t11", {31'd0, hold_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_done", seen, 0);
    check("flush_result_kept", result_o, last_res);

    // flush in idle blocks a simultaneous start
    instruction_operation_i = DIV;
    start_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_idle_block", {31'd0, hold_o}, 32'd0);

    // asynchronous reset mid-calculation
    instruction_operation_i = DIVU;
    first_operand_i = 32'd1000;
    second_operand_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_hold", {31'd0, hold_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_valid = 1'b0;
    last_res = 32'd0;
    @(posedge clk); #1;
    check("arst_no_done", {31'd0, done_o}, 32'd0);

    run_op("post_rst_div", DIV, 32'd1000, 32'd33);
    run_op("post_rst_rem", REM, 32'd1000, 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
